sim_uart_in_responder: RTL and testbench

- Simulation-side responder for the SoC UART input poll interface.
- Every cycle the DUT may assert a read request; this block answers in the same cycle with the next host-supplied character, or with an idle code when none is available.
- Host characters, for example from a DPI keyboard/script feeder, enter through a valid/ready push port into an internal FIFO.
- An optional programmable inter-character gap emulates baud-rate pacing.
- Sits in the simulation top between the host feeder and SimTop io_uart_in_valid/io_uart_in_ch.

---
 rtl/sim_uart_pkg.sv | 18 +
 rtl/sim_byte_fifo.sv | 68 ++++++
 rtl/sim_uart_in_responder.sv | 112 +++++++++++
 tb/tb_sim_uart_in_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_uart_pkg.sv
// Shared definitions for the simulation UART input responder.
//   IDLE_CH_DEFAULT : byte returned to the DUT when nothing is deliverable
//   state_e         : pacing state (READY / COOLDOWN)
//   count_w()       : width of an occupancy counter able to hold 0..depth
package sim_uart_pkg;

  localparam logic [7:0] IDLE_CH_DEFAULT = 8'hff;

  typedef enum logic [0:0] {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_e;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sim_byte_fifo.sv
// DEPTH x 8 synchronous FIFO with a combinational head view.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   push, din    : write request and data (ignored when full)
//   pop          : read request (ignored when empty)
//   head         : oldest stored byte (valid when !empty)
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module sim_byte_fifo
  import sim_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [7:0]                  din,
  input  logic                        pop,
  output logic [7:0]                  head,
  output logic [count_w(DEPTH)-1:0]   count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == FULL_COUNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage carries no reset: stale contents are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sim_uart_in_responder.sv
// Simulation-side responder for the SoC UART input poll interface.
// Host bytes are queued in a FIFO and handed to the DUT combinationally in
// the cycle it polls; an optional gap enforces idle cycles after each byte.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   host_valid/host_ch  : host byte offer; host_ready accepts it at posedge
//   uart_in_valid       : DUT poll request
//   uart_in_ch          : head byte when deliverable, IDLE_CH otherwise
//   enable              : 0 blocks all delivery
//   gap_cycles          : idle cycles after each delivered byte
//   fifo_count          : FIFO occupancy
//   delivered_count     : bytes delivered since reset (wraps)
//   overflow            : sticky, host offered while not ready
module sim_uart_in_responder
  import sim_uart_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         GAP_W   = 16,
  parameter logic [7:0] IDLE_CH = IDLE_CH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       host_valid,
  input  logic [7:0]                 host_ch,
  output logic                       host_ready,
  input  logic                       uart_in_valid,
  output logic [7:0]                 uart_in_ch,
  input  logic                       enable,
  input  logic [GAP_W-1:0]           gap_cycles,
  output logic [count_w(DEPTH)-1:0]  fifo_count,
  output logic [31:0]                delivered_count,
  output logic                       overflow
);

  state_e             r_state;
  logic [GAP_W-1:0]   r_gap_ctr;
  logic [31:0]        r_delivered;
  logic               r_overflow;

  logic [7:0]         w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_deliverable;

  sim_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .din   (host_ch),
    .pop   (w_pop),
    .head  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Readiness looks only at the registered count: no pop-to-push bypass when full.
  assign host_ready    = !reset && !w_full;
  assign w_push        = host_valid && host_ready;
  // The FIFO reads empty the instant reset asserts, so uart_in_ch falls to IDLE_CH.
  assign w_deliverable = enable && (r_state == ST_READY) && !w_empty;
  assign w_pop         = uart_in_valid && w_deliverable;
  assign uart_in_ch    = w_deliverable ? w_head : IDLE_CH;

  assign delivered_count = r_delivered;
  assign overflow        = r_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_READY;
      r_gap_ctr   <= '0;
      r_delivered <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (host_valid && !host_ready) begin
        r_overflow <= 1'b1;
      end

      if (w_pop) begin
        r_delivered <= r_delivered + 32'd1;
      end

      case (r_state)
        ST_READY: begin
          // gap_cycles is captured only here; later changes leave the running gap alone.
          if (w_pop && (gap_cycles != '0)) begin
            r_state   <= ST_COOLDOWN;
            r_gap_ctr <= gap_cycles;
          end
        end
        ST_COOLDOWN: begin
          // Counts regardless of enable; leaving at 1 yields exactly gap_cycles idle cycles.
          if (r_gap_ctr == GAP_W'(1)) begin
            r_state   <= ST_READY;
            r_gap_ctr <= '0;
          end else begin
            r_gap_ctr <= r_gap_ctr - GAP_W'(1);
          end
        end
        default: begin
          r_state   <= ST_READY;
          r_gap_ctr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_uart_in_responder.sv
// Scoreboard bench for sim_uart_in_responder: accepted host bytes are queued
// as expectations; a monitor compares every byte the DUT actually receives.
module tb_sim_uart_in_responder;

  localparam int DEPTH = 16;
  localparam int GAP_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             host_valid = 1'b0;
  logic [7:0]       host_ch = 8'h00;
  logic             host_ready;
  logic             uart_in_valid = 1'b0;
  logic [7:0]       uart_in_ch;
  logic             enable = 1'b1;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      delivered_count;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  sim_uart_in_responder #(
    .DEPTH   (DEPTH),
    .GAP_W   (GAP_W),
    .IDLE_CH (8'hff)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .host_valid      (host_valid),
    .host_ch         (host_ch),
    .host_ready      (host_ready),
    .uart_in_valid   (uart_in_valid),
    .uart_in_ch      (uart_in_ch),
    .enable          (enable),
    .gap_cycles      (gap_cycles),
    .fifo_count      (fifo_count),
    .delivered_count (delivered_count),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one byte for one cycle; it becomes an expectation only if accepted.
  task automatic push(input logic [7:0] b);
    host_valid = 1'b1;
    host_ch    = b;
    @(negedge clock);
    if (host_ready) exp_q.push_back(b);
    tick();
    host_valid = 1'b0;
  endtask

  // Monitor: every non-idle byte seen during a poll is a delivery.
  // Test bytes never use 8'hff, so the idle code is unambiguous.
  always @(negedge clock) begin
    if (!reset && uart_in_valid && (uart_in_ch != 8'hff)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected actual=%0h required=none", uart_in_ch);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (uart_in_ch !== e) begin
          n_fail++;
          $display("FAIL sb_byte actual=%0h required=%0h", uart_in_ch, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] gap_exp [12];
    int model_cnt;
    int next_b;
    int cyc;
    logic m_push;
    logic m_pop;

    // ---------------- reset ----------------
    #2;
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_uart_ch", 32'(uart_in_ch), 32'hff);
    tick();
    reset = 1'b0;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_delivered", delivered_count, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // ---------------- idle polling ----------------
    uart_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_ch", 32'(uart_in_ch), 32'hff);
      check("idle_ready", 32'(host_ready), 32'd1);
      tick();
    end
    check("idle_delivered", delivered_count, 32'd0);
    check("idle_count", 32'(fifo_count), 32'd0);
    uart_in_valid = 1'b0;

    // ---------------- back-to-back, gap 0 ----------------
    push(8'h68);
    push(8'h69);
    uart_in_valid = 1'b1;
    @(negedge clock); check("b2b_0", 32'(uart_in_ch), 32'h68); tick();
    @(negedge clock); check("b2b_1", 32'(uart_in_ch), 32'h69); tick();
    @(negedge clock); check("b2b_idle", 32'(uart_in_ch), 32'hff);
    check("b2b_delivered", delivered_count, 32'd2);
    tick();
    uart_in_valid = 1'b0;

    // ---------------- pacing gap 3 ----------------
    gap_cycles = 16'd3;
    push(8'h10);
    push(8'h11);
    push(8'h12);
    gap_exp = '{8'h10, 8'hff, 8'hff, 8'hff, 8'h11, 8'hff, 8'hff, 8'hff,
                8'h12, 8'hff, 8'hff, 8'hff};
    uart_in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check($sformatf("gap_cyc%0d", i), 32'(uart_in_ch), 32'(gap_exp[i]));
      tick();
    end
    uart_in_valid = 1'b0;
    gap_cycles = '0;
    check("gap_delivered", delivered_count, 32'd5);

    // ---------------- full / overflow ----------------
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i));
    host_valid = 1'b1;
    host_ch    = 8'h99;
    @(negedge clock);
    check("full_ready", 32'(host_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    tick();
    host_valid = 1'b0;
    @(negedge clock);
    check("ovf_set", 32'(overflow), 32'd1);
    tick();
    @(negedge clock);
    check("ovf_sticky", 32'(overflow), 32'd1);
    tick();
    uart_in_valid = 1'b1;
    tick();
    uart_in_valid = 1'b0;
    @(negedge clock);
    check("drain1_count", 32'(fifo_count), 32'(DEPTH - 1));
    check("drain1_ready", 32'(host_ready), 32'd1);
    tick();
    uart_in_valid = 1'b1;
    repeat (DEPTH) tick();
    @(negedge clock);
    check("drain_idle", 32'(uart_in_ch), 32'hff);
    check("drain_q_empty", 32'(exp_q.size()), 32'd0);
    tick();
    uart_in_valid = 1'b0;

    // ---------------- wrap-around with random interleave ----------------
    model_cnt = 0;
    next_b    = 0;
    cyc       = 0;
    while (!(next_b == 40 && model_cnt == 0) && cyc < 2000) begin
      host_valid    = (next_b < 40) && ($urandom_range(0, 1) == 1);
      host_ch       = 8'(8'h40 + next_b);
      uart_in_valid = ($urandom_range(0, 2) != 0);
      @(negedge clock);
      check("wrap_count", 32'(fifo_count), 32'(model_cnt));
      check("wrap_ready", 32'(host_ready), 32'(model_cnt != DEPTH));
      m_push = host_valid && (model_cnt != DEPTH);
      m_pop  = uart_in_valid && (model_cnt != 0);
      if (m_push) begin
        exp_q.push_back(host_ch);
        next_b++;
      end
      model_cnt = model_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      tick();
      cyc++;
    end
    host_valid    = 1'b0;
    uart_in_valid = 1'b0;
    check("wrap_done_in_budget", 32'(cyc < 2000), 32'd1);
    check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- mid-stream asynchronous reset ----------------
    gap_cycles = 16'd5;
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
    uart_in_valid = 1'b1;
    tick();
    uart_in_valid = 1'b0;
    @(negedge clock);
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    check("pre_rst_cooldown", 32'(uart_in_ch), 32'hff);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_ch", 32'(uart_in_ch), 32'hff);
    check("arst_ready", 32'(host_ready), 32'd0);
    check("arst_count", 32'(fifo_count), 32'd0);
    tick();
    reset = 1'b0;
    gap_cycles = '0;
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_delivered", delivered_count, 32'd0);
    check("post_rst_overflow", 32'(overflow), 32'd0);
    push(8'h55);
    uart_in_valid = 1'b1;
    @(negedge clock);
    check("post_rst_ready_state", 32'(uart_in_ch), 32'h55);
    tick();
    uart_in_valid = 1'b0;

    // ---------------- enable gating ----------------
    enable = 1'b0;
    push(8'h77);
    push(8'h78);
    uart_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("dis_ch", 32'(uart_in_ch), 32'hff);
      check("dis_count", 32'(fifo_count), 32'd2);
      tick();
    end
    enable = 1'b1;
    @(negedge clock); check("en_first", 32'(uart_in_ch), 32'h77); tick();
    @(negedge clock); check("en_second", 32'(uart_in_ch), 32'h78); tick();
    @(negedge clock); check("en_idle", 32'(uart_in_ch), 32'hff);
    uart_in_valid = 1'b0;
    check("final_delivered", delivered_count, 32'd3);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
